// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver, the transmitter and the baud
// counter: FSM state encodings, default frame geometry and a helper that
// derives the start-bit validation tick from the oversample ratio.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;

  // Tick index at the centre of the start bit.
  function automatic int unsigned uart_mid(input int unsigned oversample);
    return (oversample / 2) - 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Two-flop synchronizer for a single asynchronous input. Both flops load
// RESET_VAL while reset is asserted so the output is a known level at once.
// Ports:
//   i_clk    in  1  destination clock
//   i_rst_n  in  1  asynchronous active-low reset
//   i_d      in  1  asynchronous input
//   o_q      out 1  synchronized output (2 clk latency)
// -----------------------------------------------------------------------------
module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample
// UART receiver. Recovers LSB-first serial frames from rxd using a tick16
// strobe at OVERSAMPLE x baud, centre-samples every bit and presents the byte
// through a valid/ack handshake.
// Optional feature: define UART_RX_PARITY_EN to receive one parity bit between
// the data bits and the stop bit (PARITY_ODD selects odd parity).
// Ports:
//   clk          in   1          system clock
//   reset        in   1          asynchronous active-low reset
//   tick16       in   1          1-cycle strobe at OVERSAMPLE x baud
//   rxd          in   1          asynchronous serial input, idles high
//   rx_ack       in   1          consumer took rx_data; clears rx_valid/overrun_err
//   rx_data      out  DATA_BITS  last received byte
//   rx_valid     out  1          byte available, held until rx_ack
//   frame_err    out  1          1-cycle pulse: stop bit sampled low
//   overrun_err  out  1          sticky: byte completed while rx_valid was set
//   parity_err   out  1          1-cycle pulse: parity mismatch (0 without parity)
// -----------------------------------------------------------------------------
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned MID        = uart_mid(UART_OVERSAMPLE)
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick16,
  input  logic                 rxd,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W = $clog2(DATA_BITS);

  localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(MID);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = PARITY;
`else
  localparam uart_state_e AFTER_DATA = STOP;
`endif

  logic                 w_rxs;
  uart_state_e          r_state;
  logic [TCNT_W-1:0]    r_tcnt;
  logic [BCNT_W-1:0]    r_bcnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_parity_err;
`endif

  // rxd is asynchronous; the FSM only ever looks at the synchronized copy.
  bit_synchronizer #(
    .RESET_VAL (1'b1)
  ) u_rxd_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (rxd),
    .o_q     (w_rxs)
  );

  // Receive FSM, counters, shift register and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_tcnt        <= '0;
      r_bcnt        <= '0;
      r_shreg       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit     <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      // Consumer ack; a byte completing in the same cycle overrides below.
      if (rx_ack) begin
        r_rx_valid    <= 1'b0;
        r_overrun_err <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_state <= START;
            r_tcnt  <= '0;
          end
        end

        // Re-check the line at the start-bit centre to reject glitches.
        START: begin
          if (tick16) begin
            if (r_tcnt == TCNT_MID) begin
              r_tcnt <= '0;
              if (!w_rxs) begin
                r_state <= DATA;
                r_bcnt  <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end

        // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
        DATA: begin
          if (tick16) begin
            if (r_tcnt == TCNT_LAST) begin
              r_tcnt  <= '0;
              r_shreg <= {w_rxs, r_shreg[DATA_BITS-1:1]};
              if (r_bcnt == BCNT_LAST) begin
                r_bcnt  <= '0;
                r_state <= AFTER_DATA;
              end else begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
              end
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick16) begin
            if (r_tcnt == TCNT_LAST) begin
              r_tcnt    <= '0;
              r_par_bit <= w_rxs;
              r_state   <= STOP;
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end
`endif

        STOP: begin
          if (tick16) begin
            if (r_tcnt == TCNT_LAST) begin
              r_tcnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_bit ^ (^r_shreg) ^ PARITY_ODD;
`endif
              if (w_rxs) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !rx_ack) begin
                  r_overrun_err <= 1'b1;
                end
                r_state <= IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= WAIT_HIGH;
              end
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end

        // A held-low line (break) must not look like a new start bit.
        WAIT_HIGH: begin
          if (w_rxs) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_tcnt  <= '0;
        end
      endcase
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
